// File: rtl/index_decoder_strobe_pkg.sv
// Shared types and helpers for the index decoder strobe: FSM state encoding,
// HOLD legality check and a generic one-hot helper.
package decoder_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STROBE = 1'b1
  } state_t;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 255;

  // Widest index the generic helper below supports.
  localparam int ONEHOT_MAX_W = 6;
  localparam int ONEHOT_MAX_N = 1 << ONEHOT_MAX_W;

  function automatic bit hold_legal(input int hold);
    return (hold >= HOLD_MIN) && (hold <= HOLD_MAX);
  endfunction

  function automatic logic [ONEHOT_MAX_N-1:0] onehot(input logic [ONEHOT_MAX_W-1:0] idx);
    logic [ONEHOT_MAX_N-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/index_decoder_strobe_bin_to_onehot.sv
// Combinational binary-to-one-hot decoder; every W-bit index maps to one line.
module bin_to_onehot #(
  parameter int W = 2
) (
  input  logic [W-1:0]        idx,
  output logic [(1<<W)-1:0]   y
);

  always_comb begin
    y      = '0;
    y[idx] = 1'b1;
  end

endmodule

// File: rtl/index_decoder_strobe.sv
// Turns an accepted index into a HOLD-cycle one-hot strobe, with one pending
// slot and a last-cycle bypass so back-to-back requests leave no gap on y.
module index_decoder_strobe
  import decoder_pkg::*;
#(
  parameter int W    = 2,
  parameter int HOLD = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [W-1:0]       q,
  input  logic               v,
  output logic               ready,
  output logic [(1<<W)-1:0]  y,
  output logic               active,
  output logic               done,
  output state_t             state
);

  localparam int N  = 1 << W;
  localparam int CW = $clog2(HOLD) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);

  generate
    if (!hold_legal(HOLD)) begin : g_bad_hold
      $error("index_decoder_strobe: HOLD must be within 1..255");
    end
  endgenerate

  // Handshake: a transfer happens on a rising edge where v && ready; ready
  // depends only on the pending slot, never on v, so there is no comb loop.

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   y_q, y_d;
  logic           active_q, active_d;
  logic           done_q, done_d;
  logic           pend_valid_q, pend_valid_d;
  logic [W-1:0]   pend_q, pend_d;

  logic           accept;
  logic           load;
  logic           sel_pend;
  logic           clear;
  logic [W-1:0]   dec_idx;
  logic [N-1:0]   dec_y;

  assign ready   = !pend_valid_q;
  assign accept  = v && ready;
  assign dec_idx = sel_pend ? pend_q : q;

  bin_to_onehot #(.W(W)) u_dec (
    .idx (dec_idx),
    .y   (dec_y)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    load         = 1'b0;
    sel_pend     = 1'b0;
    clear        = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          load    = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
          if (accept) begin
            pend_valid_d = 1'b1;
            pend_d       = q;
          end
        end else if (pend_valid_q) begin
          load         = 1'b1;
          sel_pend     = 1'b1;
          pend_valid_d = 1'b0;
        end else if (accept) begin
          // Bypass: the new index follows directly without touching the slot.
          load = 1'b1;
        end else begin
          clear    = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        clear    = 1'b1;
        active_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (load) begin
      cnt_d    = RELOAD;
      active_d = 1'b1;
    end

    if (load)       y_d = dec_y;
    else if (clear) y_d = '0;
    else            y_d = y_q;

    // Registered form of "active && cnt == 0".
    done_d = active_d && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      y_q          <= '0;
      active_q     <= 1'b0;
      done_q       <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      y_q          <= y_d;
      active_q     <= active_d;
      done_q       <= done_d;
      pend_valid_q <= pend_valid_d;
      pend_q       <= pend_d;
    end
  end

  assign y      = y_q;
  assign active = active_q;
  assign done   = done_q;
  assign state  = state_q;

endmodule

// File: tb/tb_index_decoder_strobe.sv
// Bench for index_decoder_strobe: HOLD=3 and HOLD=1 instances checked every
// cycle against a schedule-of-strobe-cycles model, plus literal checkpoints.
module tb_index_decoder_strobe;
  import decoder_pkg::*;

  localparam int W = 2;
  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  q0, q1;
  logic          v0, v1;
  logic          ready0, ready1;
  logic          active0, active1;
  logic          done0, done1;
  logic [N-1:0]  y0, y1;
  state_t        st0, st1;

  index_decoder_strobe #(.W(W), .HOLD(3)) u_dut0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .q      (q0),
    .v      (v0),
    .ready  (ready0),
    .y      (y0),
    .active (active0),
    .done   (done0),
    .state  (st0)
  );

  index_decoder_strobe #(.W(W), .HOLD(1)) u_dut1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .q      (q1),
    .v      (v1),
    .ready  (ready1),
    .y      (y1),
    .active (active1),
    .done   (done1),
    .state  (st1)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each DUT is modelled as a list of future strobe cycles: entry 0 is the
  // cycle currently on y. An accept appends HOLD entries; each edge retires
  // one. Ready is low while two requests are scheduled (current + pending).
  int  m_hold  [2];
  int  m_idx   [2][16];
  bit  m_last  [2][16];
  int  m_cnt   [2];
  bit  m_ready [2];

  task automatic model_step(input int id, input logic rn, input logic vv, input logic [W-1:0] qq);
    bit acc;
    int lasts;
    if (!rn) begin
      m_cnt[id] = 0;
    end else begin
      acc = (vv === 1'b1) && m_ready[id];
      if (m_cnt[id] > 0) begin
        for (int i = 0; i < 15; i++) begin
          m_idx[id][i]  = m_idx[id][i+1];
          m_last[id][i] = m_last[id][i+1];
        end
        m_cnt[id]--;
      end
      if (acc) begin
        for (int i = 0; i < m_hold[id]; i++) begin
          m_idx[id][m_cnt[id]]  = int'(qq);
          m_last[id][m_cnt[id]] = (i == m_hold[id] - 1);
          m_cnt[id]++;
        end
      end
    end
    lasts = 0;
    for (int i = 0; i < m_cnt[id]; i++) if (m_last[id][i]) lasts++;
    m_ready[id] = (lasts <= 1);
  endtask

  function automatic logic [31:0] exp_y(input int id);
    return (m_cnt[id] > 0) ? (32'd1 << m_idx[id][0]) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_done(input int id);
    return ((m_cnt[id] > 0) && m_last[id][0]) ? 32'd1 : 32'd0;
  endfunction

  task automatic compare_dut(input int id, input logic [N-1:0] yy, input logic aa,
                             input logic dd, input logic rr, input state_t ss);
    check($sformatf("dut%0d_y", id),      32'(yy), exp_y(id));
    check($sformatf("dut%0d_active", id), 32'(aa), (m_cnt[id] > 0) ? 32'd1 : 32'd0);
    check($sformatf("dut%0d_done", id),   32'(dd), exp_done(id));
    check($sformatf("dut%0d_ready", id),  32'(rr), m_ready[id] ? 32'd1 : 32'd0);
    check($sformatf("dut%0d_state", id),  32'(ss), (m_cnt[id] > 0) ? 32'(STROBE) : 32'(IDLE));
  endtask

  // Compare process: advance the model on each edge, check 1 time unit later.
  always @(posedge clk) begin
    model_step(0, rst_n, v0, q0);
    model_step(1, rst_n, v1, q1);
    #1;
    compare_dut(0, y0, active0, done0, ready0, st0);
    compare_dut(1, y1, active1, done1, ready1, st1);
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    m_hold[0] = 3;
    m_hold[1] = 1;
    m_cnt[0] = 0;  m_cnt[1] = 0;
    m_ready[0] = 1'b1; m_ready[1] = 1'b1;
    rst_n = 1'b0;
    v0 = 1'b0; q0 = '0;
    v1 = 1'b0; q1 = '0;

    // Reset for two edges, then release.
    repeat (2) tick();
    rst_n = 1'b1;
    check("rst_y",      32'(y0),      32'h0);
    check("rst_active", 32'(active0), 32'h0);
    check("rst_done",   32'(done0),   32'h0);
    check("rst_ready",  32'(ready0),  32'h1);

    // Single request q=2.
    q0 = 2'd2; v0 = 1'b1;
    tick(); v0 = 1'b0;
    check("single_t1_y", 32'(y0), 32'b0100); check("single_t1_done", 32'(done0), 32'h0);
    tick();
    check("single_t2_y", 32'(y0), 32'b0100); check("single_t2_done", 32'(done0), 32'h0);
    tick();
    check("single_t3_y", 32'(y0), 32'b0100); check("single_t3_done", 32'(done0), 32'h1);
    tick();
    check("single_t4_y", 32'(y0), 32'b0000); check("single_t4_active", 32'(active0), 32'h0);

    // Queued request: 1 then 3.
    q0 = 2'd1; v0 = 1'b1;
    tick();
    check("queue_t1_y", 32'(y0), 32'b0010); check("queue_t1_ready", 32'(ready0), 32'h1);
    q0 = 2'd3;
    tick(); v0 = 1'b0;
    check("queue_t2_y", 32'(y0), 32'b0010); check("queue_t2_ready", 32'(ready0), 32'h0);
    tick();
    check("queue_t3_ready", 32'(ready0), 32'h0); check("queue_t3_done", 32'(done0), 32'h1);
    tick();
    check("queue_t4_y", 32'(y0), 32'b1000); check("queue_t4_ready", 32'(ready0), 32'h1);
    check("queue_t4_done", 32'(done0), 32'h0);
    tick(); tick();
    check("queue_t6_y", 32'(y0), 32'b1000); check("queue_t6_done", 32'(done0), 32'h1);
    tick();
    check("queue_t7_y", 32'(y0), 32'b0000);

    // Bypass: q=0, then q=3 presented only on the last strobe cycle.
    q0 = 2'd0; v0 = 1'b1;
    tick(); v0 = 1'b0;
    check("bypass_t1_y", 32'(y0), 32'b0001);
    tick(); tick();
    check("bypass_t3_done", 32'(done0), 32'h1); check("bypass_t3_ready", 32'(ready0), 32'h1);
    q0 = 2'd3; v0 = 1'b1;
    tick(); v0 = 1'b0;
    check("bypass_t4_y", 32'(y0), 32'b1000); check("bypass_t4_ready", 32'(ready0), 32'h1);
    check("bypass_t4_done", 32'(done0), 32'h0);
    tick(); tick();
    check("bypass_t6_done", 32'(done0), 32'h1);
    tick();
    check("bypass_t7_y", 32'(y0), 32'b0000);

    // Reset mid-strobe with a queued index.
    q0 = 2'd1; v0 = 1'b1;
    tick(); q0 = 2'd2;
    tick(); v0 = 1'b0;
    check("midrst_pend_ready", 32'(ready0), 32'h0);
    rst_n = 1'b0;
    tick(); rst_n = 1'b1;
    check("midrst_y",      32'(y0),      32'h0);
    check("midrst_done",   32'(done0),   32'h0);
    check("midrst_active", 32'(active0), 32'h0);
    check("midrst_ready",  32'(ready0),  32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_after_y", 32'(y0), 32'h0);
    end

    // HOLD=1 continuous stream 0,1,2,3.
    q1 = 2'd0; v1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("hold1_y",     32'(y1),     32'd1 << k);
      check("hold1_done",  32'(done1),  32'h1);
      check("hold1_ready", 32'(ready1), 32'h1);
      if (k < 3) q1 = 2'(k + 1);
      else       v1 = 1'b0;
    end
    tick();
    check("hold1_end_y", 32'(y1), 32'h0); check("hold1_end_active", 32'(active1), 32'h0);

    // Mixed traffic on both instances; source holds q/v while stalled.
    for (int c = 0; c < 120; c++) begin
      if (!(v0 && !ready0)) begin
        v0 = ($urandom_range(0, 3) != 0);
        q0 = 2'($urandom_range(0, 3));
      end
      if (!(v1 && !ready1)) begin
        v1 = ($urandom_range(0, 2) != 0);
        q1 = 2'($urandom_range(0, 3));
      end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/index_decoder_strobe.md
Name: index_decoder_strobe

Overview:
- Inverse of the team's priority encoder path: accepts an encoded index `q` with valid `v` and drives the matching one-hot line `y` for a fixed number of cycles.
- Sits downstream of the encoder/arbiter and turns the winning index into a timed strobe on a request or interrupt line.
- Holds one pending request, so back-to-back indices arrive with no idle gap.

Parameters:
- W, 2, index width in bits; output width N = 2**W (localparam).
- HOLD, 3, cycles each one-hot strobe stays asserted; legal range 1..255.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- q  input  W  encoded index.
- v  input  1  index valid.
- ready  output  1  block can accept; transfer occurs on a rising edge where v && ready.
- y  output  N  registered one-hot strobe, y[q] = 1 while active.
- active  output  1  registered, high while any strobe is driven.
- done  output  1  registered, one-cycle pulse on the last strobe cycle of each request.

Behaviour:
- Reset (rst_n low at a rising edge): y=0, active=0, done=0, state=IDLE, counter=0, pending slot empty. Reset has priority over every other event.
- ready = !pend_valid (combinational). It is 1 from the first cycle after reset.
- States are IDLE and STROBE, with a down-counter cnt of width clog2(HOLD)+1.
- IDLE, accept of index k at edge t: y=onehot(k), active=1, cnt=HOLD-1, state=STROBE. The strobe covers cycles t+1..t+HOLD; latency is 1 cycle.
- STROBE, cnt!=0: cnt decrements. An accept in this state stores q into the pending slot (pend_valid=1), so ready is 0 from the next cycle.
- STROBE, cnt==0 (last strobe cycle): done=1 in this cycle, asserted from the edge that loaded cnt=0. At the closing edge, the first matching case applies:
  - pending valid: y=onehot(pend), cnt=HOLD-1, pend_valid=0, stay in STROBE.
  - no pending, but accept this cycle: bypass, y=onehot(q), cnt=HOLD-1, stay in STROBE. The pending slot stays empty.
  - otherwise: y=0, active=0, state=IDLE.
- done must be 1 exactly on cycles where active && cnt==0. Implement it registered; the output is equivalent to that condition.
- Back-to-back requests produce no zero cycle on y between strobes. Exactly one bit of y is high whenever active=1, and y=0 whenever active=0.
- HOLD=1: every strobe cycle is a last cycle. A continuous stream is accepted every cycle through the bypass path, ready stays 1, and done is high every active cycle.
- Pending slot full while v stays high: no accept occurs. The upstream source holds q and v stable until ready.
- Reset mid-strobe: the current strobe and the pending index are discarded, with no done pulse. y=0 from the cycle after the reset edge.
- Every W-bit value of q is a legal index; no out-of-range case exists.

Decomposition:
- Shared package (decoder_pkg):
  - state enum {IDLE, STROBE}.
  - function onehot(idx) returning N bits.
  - HOLD range-check constant.
- Sub-module: bin_to_onehot (combinational, parameter W). It is instantiated once on the mux of q and the pending index, and feeds the y register.

Test Plan:
- Reset: rst_n=0 for 2 cycles, then 1 → y=0000, active=0, done=0, ready=1.
- Single request: q=2, v=1 for one cycle → y=0100 for cycles t+1..t+3, done=1 only at t+3, y=0000 and active=0 at t+4.
- Queued request: q=1 at t, q=3 at t+1, v dropped after → ready=0 during t+2..t+3. y=0010 ×3 then 1000 ×3 with no gap, done at t+3 and t+6.
- Bypass: q=0 accepted at t; v=1 with q=3 presented only at t+3 → y=0001 ×3 then 1000 ×3, pend_valid never set, ready stays 1.
- Reset mid-operation: q=1 accepted at t, q=2 queued at t+1, rst_n=0 at t+2 → y=0000 from t+3, no done, ready=1, the queued index is never driven.
- HOLD=1 stream: v=1 with q=0,1,2,3 on consecutive cycles → y=0001, 0010, 0100, 1000 on consecutive cycles, done=1 each cycle, ready constantly 1.
